// File: rtl/not8_serial_rx.sv
// not8_serial_rx: bit-serial receiver, LSB first, that presents the bitwise
// complement of each received 8-bit word on a registered parallel output.
//
// Optional feature macro: NOT8_RX_PARITY_EN
//   undefined : 8-bit frames, out_perr tied to 0.
//   defined   : 9-bit frames (8 data bits then one even-parity bit); out_perr
//               flags an odd count of ones across the 9 raw bits.
//
// Handshakes (both sides use the same rule): a transfer happens on a rising
// clk edge where valid && ready. in_ready depends only on registered state
// and out_ready, never on in_valid. Only the frame-completing bit can be
// stalled, and only while a previous word is still waiting on out.
module not8_serial_rx (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sync,
    output logic [7:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_perr
);

`ifdef NOT8_RX_PARITY_EN
    // Index of the frame-completing bit: the parity bit.
    localparam logic [3:0] LAST = 4'd8;
    localparam int         SR_W = 8;
`else
    // Index of the frame-completing bit: data bit 7, which bypasses sr.
    localparam logic [3:0] LAST = 4'd7;
    localparam int         SR_W = 7;
`endif

    // Bits that arrive before the completing bit are parked here.
    logic [SR_W-1:0] sr_q, sr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      out_q, out_d;
    logic            out_valid_q, out_valid_d;

    logic            take;
    logic            at_last;
    logic            frame_done;
    logic [7:0]      word;

    assign at_last    = (cnt_q == LAST);
    assign in_ready   = !(at_last && out_valid_q && !out_ready);
    assign take       = in_valid && in_ready;
    // A sync in the same cycle restarts the frame, so the bit becomes bit 0.
    assign frame_done = take && !in_sync && at_last;

`ifdef NOT8_RX_PARITY_EN
    assign word = sr_q;
`else
    assign word = {in_bit, sr_q};
`endif

    assign out       = out_q;
    assign out_valid = out_valid_q;

    // Next-state for the shift register and bit counter.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (in_sync) begin
            sr_d  = '0;
            cnt_d = 4'd0;
            if (take) begin
                sr_d[0] = in_bit;
                cnt_d   = 4'd1;
            end
        end else if (take) begin
            if (at_last) begin
                cnt_d = 4'd0;
            end else begin
                for (int i = 0; i < SR_W; i++) begin
                    if (cnt_q == i[3:0]) begin
                        sr_d[i] = in_bit;
                    end
                end
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Next-state for the output holding register; a completing frame wins
    // over a consume so back-to-back words leave no bubble.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (frame_done) begin
            out_d       = ~word;
            out_valid_d = 1'b1;
        end
    end

    // State registers for frame assembly and the output word.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q        <= '0;
            cnt_q       <= 4'd0;
            out_q       <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef NOT8_RX_PARITY_EN
    // Running XOR of the bits accepted so far in the current frame.
    logic par_q, par_d;
    logic perr_q, perr_d;

    // Next-state for the running parity and the error flag paired with out.
    always_comb begin
        par_d  = par_q;
        perr_d = perr_q;
        if (in_sync) begin
            par_d = take ? in_bit : 1'b0;
        end else if (take) begin
            par_d = at_last ? 1'b0 : (par_q ^ in_bit);
        end
        if (frame_done) begin
            perr_d = par_q ^ in_bit;
        end
    end

    // Parity registers, cleared with the rest of the receiver.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end

    assign out_perr = perr_q;
`else
    assign out_perr = 1'b0;
`endif

endmodule

// File: tb/tb_not8_serial_rx.sv
// Testbench for not8_serial_rx: directed scenarios followed by randomized
// traffic, all checked against a frame-level reference model.
module tb_not8_serial_rx;

`ifdef NOT8_RX_PARITY_EN
  localparam int M_LAST = 8;
`else
  localparam int M_LAST = 7;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk;
  logic       rst;
  logic       ib;
  logic       iv;
  logic       isync;
  logic       ordy;
  logic       in_ready;
  logic [7:0] out;
  logic       out_valid;
  logic       out_perr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  not8_serial_rx dut (
    .clk       (clk),
    .reset     (rst),
    .in_bit    (ib),
    .in_valid  (iv),
    .in_ready  (in_ready),
    .in_sync   (isync),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (ordy),
    .out_perr  (out_perr)
  );

  // ---------------- reference model ----------------
  bit         bits_q[$];   // raw bits of the frame in progress
  logic [7:0] exp_q[$];    // words expected to be consumed, in order
  logic [7:0] m_out;
  bit         m_ov;
  bit         m_perr;
  bit         m_took;
  bit         seen_ready;

  int n_chk;
  int n_pass;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit model_ready(input bit o);
    return !(bits_q.size() == M_LAST && m_ov && !o);
  endfunction

  // One clock edge of behaviour, computed from the current tb inputs.
  task automatic model_step();
    bit rdy;
    bit take;
    bit consumed;
    logic [7:0] word;
    int ones;
    m_took = 1'b0;
    if (rst) begin
      bits_q.delete();
      exp_q.delete();
      m_out  = 8'h00;
      m_ov   = 1'b0;
      m_perr = 1'b0;
      return;
    end
    rdy      = model_ready(ordy);
    take     = iv && rdy;
    m_took   = take;
    consumed = m_ov && ordy;
    if (consumed && exp_q.size() > 0) void'(exp_q.pop_front());
    if (isync) bits_q.delete();
    if (take && bits_q.size() == M_LAST) begin
      bits_q.push_back(ib);
      word = 8'h00;
      ones = 0;
      for (int i = 0; i < bits_q.size(); i++) begin
        if (i < 8) word[i] = bits_q[i];
        ones += int'(bits_q[i]);
      end
      bits_q.delete();
      m_out  = ~word;
      m_ov   = 1'b1;
      m_perr = (M_LAST == 8) ? ones[0] : 1'b0;
      exp_q.push_back(~word);
    end else begin
      if (take) bits_q.push_back(ib);
      if (consumed) m_ov = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the next falling edge.
  task automatic drive_cycle(input bit r, input bit v, input bit b, input bit s, input bit o);
    rst = r; iv = v; ib = b; isync = s; ordy = o;
    #1;
    seen_ready = in_ready;
    check("in_ready", {8'h00, in_ready}, {8'h00, (r ? 1'b1 : model_ready(o))});
    check("out_valid", {8'h00, out_valid}, {8'h00, m_ov});
    check("out", {1'b0, out}, {1'b0, m_out});
    check("out_perr", {8'h00, out_perr}, {8'h00, m_perr});
    if (!r && m_ov && o && exp_q.size() > 0) check("consume", {1'b0, out}, {1'b0, exp_q[0]});
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic send_bit(input bit b, input bit s, input bit o);
    bit sy;
    sy = s;
    for (int k = 0; k < 32; k++) begin
      drive_cycle(1'b0, 1'b1, b, sy, o);
      sy = 1'b0;
      if (m_took) return;
    end
    check("send_timeout", 9'd1, 9'd0);
  endtask

  function automatic bit frame_bit(input logic [7:0] w, input int i, input bit badpar);
    if (i < 8) return w[i];
    return (^w) ^ badpar;
  endfunction

  task automatic send_word(input logic [7:0] w, input bit s, input bit o, input bit badpar);
    for (int i = 0; i <= M_LAST; i++) send_bit(frame_bit(w, i, badpar), (i == 0) ? s : 1'b0, o);
  endtask

  task automatic idle(input int n, input bit o);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, o);
  endtask

  // ---------------- stimulus ----------------
  bit hold;
  bit hb;
  bit fb_last;

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; iv = 1'b0; ib = 1'b0; isync = 1'b0; ordy = 1'b0;
    m_out = 8'h00; m_ov = 1'b0; m_perr = 1'b0;
    @(negedge clk);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state and a frame of zeros.
    check("rst_out_valid", {8'h00, out_valid}, 9'd0);
    check("rst_out", {1'b0, out}, 9'h000);
    check("rst_in_ready", {8'h00, in_ready}, 9'd1);
    send_word(8'h00, 1'b0, 1'b0, 1'b0);
    check("w00_out", {1'b0, out}, 9'h0FF);
    check("w00_valid", {8'h00, out_valid}, 9'd1);
    check("w00_perr", {8'h00, out_perr}, 9'd0);

    // Back-to-back frames with the consumer always ready.
    idle(2, 1'b1);
    send_word(8'hAA, 1'b0, 1'b1, 1'b0);
    check("wAA_out", {1'b0, out}, 9'h055);
    send_word(8'h3C, 1'b0, 1'b1, 1'b0);
    check("w3C_out", {1'b0, out}, 9'h0C3);
    check("w3C_valid", {8'h00, out_valid}, 9'd1);

    // Backpressure: second frame's completing bit stalls until out_ready.
    idle(2, 1'b1);
    send_word(8'h12, 1'b0, 1'b0, 1'b0);
    check("w12_out", {1'b0, out}, 9'h0ED);
    for (int i = 0; i < M_LAST; i++) send_bit(frame_bit(8'hFF, i, 1'b0), 1'b0, 1'b0);
    fb_last = frame_bit(8'hFF, M_LAST, 1'b0);
    drive_cycle(1'b0, 1'b1, fb_last, 1'b0, 1'b0);
    check("stall_ready", {8'h00, seen_ready}, 9'd0);
    check("stall_out", {1'b0, out}, 9'h0ED);
    drive_cycle(1'b0, 1'b1, fb_last, 1'b0, 1'b1);
    check("release_ready", {8'h00, seen_ready}, 9'd1);
    check("wFF_out", {1'b0, out}, 9'h000);
    check("wFF_valid", {8'h00, out_valid}, 9'd1);

    // Sync discards a partial frame.
    idle(2, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b1);
    send_word(8'h0F, 1'b1, 1'b1, 1'b0);
    check("sync_out", {1'b0, out}, 9'h0F0);

    // Reset mid-frame with a pending word.
    idle(2, 1'b1);
    send_word(8'h12, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mrst_valid", {8'h00, out_valid}, 9'd0);
    check("mrst_out", {1'b0, out}, 9'h000);
    check("mrst_ready", {8'h00, in_ready}, 9'd1);
    send_word(8'h5A, 1'b0, 1'b1, 1'b0);
    check("mrst_next", {1'b0, out}, 9'h0A5);

`ifdef NOT8_RX_PARITY_EN
    idle(2, 1'b1);
    send_word(8'h03, 1'b0, 1'b1, 1'b0);
    check("par_ok_out", {1'b0, out}, 9'h0FC);
    check("par_ok_perr", {8'h00, out_perr}, 9'd0);
    send_word(8'h03, 1'b0, 1'b1, 1'b1);
    check("par_bad_out", {1'b0, out}, 9'h0FC);
    check("par_bad_perr", {8'h00, out_perr}, 9'd1);
`endif

    // Randomized traffic: gaps, syncs, backpressure and rare resets.
    hold = 1'b0;
    hb   = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (hold) begin
        drive_cycle(1'b0, 1'b1, hb, 1'b0, ($urandom_range(0, 3) == 0));
      end else if ($urandom_range(0, 299) == 0) begin
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        hb = 1'($urandom_range(0, 1));
        drive_cycle(1'b0, ($urandom_range(0, 9) < 7), hb,
                    ($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1));
      end
      hold = iv && !m_took && !rst;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
